// File: rtl/sdram_slot_arbiter.sv
// Three-client slot arbiter in front of the sdram controller: one client per clk_8 period,
// controller inputs held for the whole slot, with forced idle slots for auto-refresh.
module sdram_slot_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int REFRESH_MAX  = 64,
   parameter int READ_PHASE   = 6
) (
   input  logic        clk_64,
   input  logic        reset,
   input  logic        clk_8,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [23:0] cpu_addr,
   input  logic [1:0]  cpu_ds,
   input  logic [15:0] cpu_din,
   output logic        cpu_ack,
   output logic [15:0] cpu_dout,
   input  logic        vid_req,
   input  logic        vid_we,
   input  logic [23:0] vid_addr,
   input  logic [1:0]  vid_ds,
   input  logic [15:0] vid_din,
   output logic        vid_ack,
   output logic [15:0] vid_dout,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [23:0] aux_addr,
   input  logic [1:0]  aux_ds,
   input  logic [15:0] aux_din,
   output logic        aux_ack,
   output logic [15:0] aux_dout,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_ds,
   output logic        mem_oe,
   output logic        mem_we,
   input  logic [15:0] mem_dout
);
   localparam int BW = $clog2(REFRESH_MAX);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [BW-1:0] BUSY_MAX = BW'(REFRESH_MAX - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_AUX} owner_t;

   logic          c8_q;
   logic [2:0]    phase_q, phase_d;
   owner_t        owner_q, owner_d, grant;
   logic [BW-1:0] busy_q, busy_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          mem_oe_q, mem_oe_d, mem_we_q, mem_we_d;
   logic [23:0]   addr_q, addr_d;
   logic [15:0]   din_q, din_d;
   logic [1:0]    ds_q, ds_d;
   logic          cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d, aux_ack_q, aux_ack_d;
   logic [15:0]   cpu_dout_q, cpu_dout_d, vid_dout_q, vid_dout_d, aux_dout_q, aux_dout_d;
   logic          sel_we;
   logic [23:0]   sel_addr;
   logic [15:0]   sel_din;
   logic [1:0]    sel_ds;

   always_ff @(posedge clk_64) begin
      if (reset) begin
         c8_q       <= 1'b0;
         phase_q    <= 3'd0;
         owner_q    <= OWN_NONE;
         busy_q     <= '0;
         starve_q   <= '0;
         mem_oe_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         ds_q       <= '0;
         cpu_ack_q  <= 1'b0;
         vid_ack_q  <= 1'b0;
         aux_ack_q  <= 1'b0;
         cpu_dout_q <= '0;
         vid_dout_q <= '0;
         aux_dout_q <= '0;
      end else begin
         c8_q       <= clk_8;
         phase_q    <= phase_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         starve_q   <= starve_d;
         mem_oe_q   <= mem_oe_d;
         mem_we_q   <= mem_we_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         ds_q       <= ds_d;
         cpu_ack_q  <= cpu_ack_d;
         vid_ack_q  <= vid_ack_d;
         aux_ack_q  <= aux_ack_d;
         cpu_dout_q <= cpu_dout_d;
         vid_dout_q <= vid_dout_d;
         aux_dout_q <= aux_dout_d;
      end
   end

   // Refresh beats everything; a starved aux jumps ahead of cpu but never ahead of vid.
   always_comb begin
      grant = OWN_NONE;
      if (busy_q == BUSY_MAX)                     grant = OWN_NONE;
      else if (vid_req)                           grant = OWN_VID;
      else if (aux_req && starve_q >= STARVE_MAX) grant = OWN_AUX;
      else if (cpu_req)                           grant = OWN_CPU;
      else if (aux_req)                           grant = OWN_AUX;
   end

   always_comb begin
      sel_we   = cpu_we;
      sel_addr = cpu_addr;
      sel_din  = cpu_din;
      sel_ds   = cpu_ds;
      case (grant)
         OWN_VID: begin
            sel_we   = vid_we;
            sel_addr = vid_addr;
            sel_din  = vid_din;
            sel_ds   = vid_ds;
         end
         OWN_AUX: begin
            sel_we   = aux_we;
            sel_addr = aux_addr;
            sel_din  = aux_din;
            sel_ds   = aux_ds;
         end
         default: ;
      endcase
   end

   always_comb begin
      phase_d    = (clk_8 && !c8_q) ? 3'd1 : phase_q + 3'd1;
      owner_d    = owner_q;
      busy_d     = busy_q;
      starve_d   = starve_q;
      mem_oe_d   = mem_oe_q;
      mem_we_d   = mem_we_q;
      addr_d     = addr_q;
      din_d      = din_q;
      ds_d       = ds_q;
      cpu_ack_d  = 1'b0;
      vid_ack_d  = 1'b0;
      aux_ack_d  = 1'b0;
      cpu_dout_d = cpu_dout_q;
      vid_dout_d = vid_dout_q;
      aux_dout_d = aux_dout_q;
      if (phase_q == 3'd7) begin
         owner_d = grant;
         if (grant == OWN_NONE) begin
            mem_oe_d = 1'b0;
            mem_we_d = 1'b0;
            busy_d   = '0;
         end else begin
            mem_oe_d = ~sel_we;
            mem_we_d = sel_we;
            addr_d   = sel_addr;
            din_d    = sel_din;
            ds_d     = sel_ds;
            if (busy_q != BUSY_MAX) busy_d = busy_q + BW'(1);
         end
         if (!aux_req || grant == OWN_AUX)                    starve_d = '0;
         else if (grant == OWN_CPU && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
      end
      // Only read slots update the owner's read-data register.
      if (phase_q == 3'(READ_PHASE) && mem_oe_q) begin
         case (owner_q)
            OWN_CPU: cpu_dout_d = mem_dout;
            OWN_VID: vid_dout_d = mem_dout;
            OWN_AUX: aux_dout_d = mem_dout;
            default: ;
         endcase
      end
      if (phase_q == 3'd6) begin
         cpu_ack_d = (owner_q == OWN_CPU);
         vid_ack_d = (owner_q == OWN_VID);
         aux_ack_d = (owner_q == OWN_AUX);
      end
   end

   assign mem_addr = addr_q;
   assign mem_din  = din_q;
   assign mem_ds   = ds_q;
   assign mem_oe   = mem_oe_q;
   assign mem_we   = mem_we_q;
   assign cpu_ack  = cpu_ack_q;
   assign vid_ack  = vid_ack_q;
   assign aux_ack  = aux_ack_q;
   assign cpu_dout = cpu_dout_q;
   assign vid_dout = vid_dout_q;
   assign aux_dout = aux_dout_q;
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: a slot-level reference model pushes one expected
// record per grant decision; the monitor checks the controller port and acks against it.
module tb_sdram_slot_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int REFRESH_MAX  = 64;
   localparam int READ_PHASE   = 6;

   logic clk_64 = 1'b0, clk_8 = 1'b0, reset = 1'b1;
   logic cpu_req = 0, cpu_we = 0, vid_req = 0, vid_we = 0, aux_req = 0, aux_we = 0;
   logic [23:0] cpu_addr = 0, vid_addr = 0, aux_addr = 0;
   logic [1:0]  cpu_ds = 0, vid_ds = 0, aux_ds = 0;
   logic [15:0] cpu_din = 0, vid_din = 0, aux_din = 0;
   logic cpu_ack, vid_ack, aux_ack;
   logic [15:0] cpu_dout, vid_dout, aux_dout;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_ds;
   logic mem_oe, mem_we;
   logic [15:0] mem_dout = 0;

   sdram_slot_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .REFRESH_MAX(REFRESH_MAX),
                        .READ_PHASE(READ_PHASE)) dut (
      .clk_64(clk_64), .reset(reset), .clk_8(clk_8),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
      .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_ds(vid_ds),
      .vid_din(vid_din), .vid_ack(vid_ack), .vid_dout(vid_dout),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_ds(aux_ds),
      .aux_din(aux_din), .aux_ack(aux_ack), .aux_dout(aux_dout),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds), .mem_oe(mem_oe),
      .mem_we(mem_we), .mem_dout(mem_dout));

   always #5 clk_64 = ~clk_64;
   initial begin
      #2;
      forever #40 clk_8 = ~clk_8;
   end

   typedef struct {
      int          own;   // 0 none, 1 cpu, 2 vid, 3 aux
      logic        we;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  ds;
      logic [15:0] rdata;
   } slot_t;

   slot_t       sb[$];
   logic [2:0]  alog[$];
   int          n_cmp = 0, n_err = 0;
   int          ph = 0, busy = 0, starve = 0;
   logic        c8m = 0;
   logic [23:0] last_addr = 0;
   logic [15:0] last_din = 0;
   logic [1:0]  last_ds = 0;
   int          ack_cnt[3];
   logic [2:0]  oneshot = 3'b000;  // bit0 cpu, bit1 vid, bit2 aux
   logic        force_rd_en = 0;
   logic [15:0] force_rd = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] onehot(input int own);
      case (own)
         1: return 3'b100;
         2: return 3'b010;
         3: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [15:0] dout_of(input int own);
      case (own)
         1: return cpu_dout;
         2: return vid_dout;
         default: return aux_dout;
      endcase
   endfunction

   task automatic model();
      slot_t r;
      int    own;
      if (reset) begin
         ph = 0; c8m = 0; busy = 0; starve = 0;
         sb.delete();
         last_addr = 0; last_din = 0; last_ds = 0;
      end else begin
         if (ph == 7) begin
            if (busy == REFRESH_MAX - 1)                  own = 0;
            else if (vid_req)                             own = 2;
            else if (aux_req && starve >= STARVE_LIMIT)   own = 3;
            else if (cpu_req)                             own = 1;
            else if (aux_req)                             own = 3;
            else                                          own = 0;
            busy = (own == 0) ? 0 : ((busy + 1 > REFRESH_MAX - 1) ? REFRESH_MAX - 1 : busy + 1);
            if (!aux_req || own == 3) starve = 0;
            else if (own == 1 && starve < STARVE_LIMIT) starve++;
            r.we = 1'b0;
            case (own)
               1: begin r.we = cpu_we; last_addr = cpu_addr; last_din = cpu_din; last_ds = cpu_ds; end
               2: begin r.we = vid_we; last_addr = vid_addr; last_din = vid_din; last_ds = vid_ds; end
               3: begin r.we = aux_we; last_addr = aux_addr; last_din = aux_din; last_ds = aux_ds; end
               default: ;
            endcase
            r.own = own; r.addr = last_addr; r.din = last_din; r.ds = last_ds;
            r.rdata = force_rd_en ? force_rd : 16'($urandom);
            sb.push_back(r);
         end
         ph = (clk_8 && !c8m) ? 1 : (ph + 1) % 8;
         c8m = clk_8;
      end
   endtask

   task automatic monitor();
      slot_t      r;
      logic [2:0] acks;
      acks = {cpu_ack, vid_ack, aux_ack};
      if (!reset) begin
         if (sb.size() == 0) begin
            chk("noslot_oe", mem_oe, 0);
            chk("noslot_we", mem_we, 0);
            chk("noslot_ack", acks, 0);
         end else begin
            r = sb[0];
            chk("slot_oe", mem_oe, (r.own != 0) && !r.we);
            chk("slot_we", mem_we, (r.own != 0) && r.we);
            chk("slot_ack", acks, (ph == 7) ? onehot(r.own) : 3'b000);
            if (ph == 0) begin
               chk("slot_addr", mem_addr, r.addr);
               chk("slot_din", mem_din, r.din);
               chk("slot_ds", mem_ds, r.ds);
            end
            if (ph == 7) begin
               if (r.own != 0 && !r.we) chk("rd_dout", dout_of(r.own), r.rdata);
               alog.push_back(acks);
               void'(sb.pop_front());
            end
         end
      end
      mem_dout = (ph == 6 && sb.size() > 0) ? sb[0].rdata : 16'($urandom);
      if (cpu_ack) begin ack_cnt[0]++; if (oneshot[0]) cpu_req = 0; end
      if (vid_ack) begin ack_cnt[1]++; if (oneshot[1]) vid_req = 0; end
      if (aux_ack) begin ack_cnt[2]++; if (oneshot[2]) aux_req = 0; end
   endtask

   task automatic step();
      @(posedge clk_64);
      model();
      @(negedge clk_64);
      monitor();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
      alog.delete();
   endtask

   task automatic wait_ack(input int c, input int budget);
      int start, n;
      start = ack_cnt[c];
      n = 0;
      while (ack_cnt[c] == start && n < budget) begin
         step();
         n++;
      end
      chk("ack_timeout", ack_cnt[c] != start, 1);
   endtask

   function automatic int first_nz();
      for (int i = 0; i < alog.size(); i++)
         if (alog[i] != 3'b000) return i;
      return -1;
   endfunction

   initial begin
      int f, n;
      logic [2:0] nz[$];
      for (int i = 0; i < 3; i++) ack_cnt[i] = 0;

      // reset values
      reset = 1;
      run(3);
      chk("rst_oe", mem_oe, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_din", mem_din, 0);
      chk("rst_ds", mem_ds, 0);
      chk("rst_acks", {cpu_ack, vid_ack, aux_ack}, 0);
      chk("rst_douts", {cpu_dout, vid_dout, aux_dout}, 0);
      reset = 0;

      // ten slots without requests
      clear_counts();
      run(80);
      chk("idle_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 0);

      // single cpu read
      cpu_addr = 24'h012345; cpu_we = 0; cpu_ds = 2'b11;
      force_rd_en = 1; force_rd = 16'hBEEF;
      oneshot = 3'b111;
      cpu_req = 1;
      wait_ack(0, 40);
      force_rd_en = 0;
      chk("cpu_rd_dout", cpu_dout, 16'hBEEF);
      run(16);
      chk("cpu_rd_once", ack_cnt[0], 1);

      // cpu and vid requesting together: vid first, each exactly once
      clear_counts();
      cpu_addr = 24'h000100; cpu_we = 1; cpu_din = 16'h1234; cpu_ds = 2'b01;
      vid_addr = 24'h200000; vid_we = 0;
      cpu_req = 1; vid_req = 1;
      run(48);
      nz.delete();
      foreach (alog[i]) if (alog[i] != 3'b000) nz.push_back(alog[i]);
      chk("cv_grants", nz.size(), 2);
      if (nz.size() >= 2) begin
         chk("cv_first_vid", nz[0], 3'b010);
         chk("cv_then_cpu", nz[1], 3'b100);
      end
      chk("cv_cpu_once", ack_cnt[0], 1);
      chk("cv_vid_once", ack_cnt[1], 1);

      // cpu and aux continuous: aux every fifth slot
      run(16);
      clear_counts();
      oneshot = 3'b000;
      cpu_we = 0; aux_we = 1; aux_addr = 24'hABCDEF; aux_din = 16'h5A5A; aux_ds = 2'b10;
      cpu_req = 1; aux_req = 1;
      run(200);
      cpu_req = 0; aux_req = 0;
      run(16);
      f = first_nz();
      chk("starve_start", (f >= 0) && (alog.size() >= f + 20), 1);
      if (f >= 0 && alog.size() >= f + 20)
         for (int k = 0; k < 20; k++)
            chk("starve_pat", alog[f + k], (k % 5 == 4) ? 3'b001 : 3'b100);

      // vid continuous for 200+ slots: forced refresh slot every 64th
      clear_counts();
      vid_req = 1;
      run(205 * 8);
      vid_req = 0;
      run(16);
      f = first_nz();
      chk("refresh_start", (f >= 0) && (alog.size() >= f + 200), 1);
      if (f >= 0 && alog.size() >= f + 200)
         for (int k = 0; k < 200; k++)
            chk("refresh_pat", alog[f + k], (k % 64 == 63) ? 3'b000 : 3'b010);

      // reset in the middle of a cpu write
      oneshot = 3'b111;
      cpu_we = 1; cpu_addr = 24'h0F0F0F; cpu_din = 16'hC0DE; cpu_ds = 2'b11;
      cpu_req = 1;
      n = 0;
      while (!(mem_we === 1'b1 && ph == 3) && n < 64) begin
         step();
         n++;
      end
      chk("rst_mid_found", (mem_we === 1'b1) && (ph == 3), 1);
      reset = 1; cpu_req = 0;
      clear_counts();
      step();
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_oe", mem_oe, 0);
      chk("rst_mid_addr", mem_addr, 0);
      reset = 0;
      run(32);
      chk("rst_mid_no_ack", ack_cnt[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
